// File: rtl/dff_bank_rr_arbiter_pkg.sv
// Shared types and width helpers for the round-robin arbiter in front of one DFF bank.
package dff_bank_rr_arbiter_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int N_DEFAULT     = 4;
  localparam int WIDTH_DEFAULT = 8;
  localparam int IDX_W         = idx_width(N_DEFAULT);

endpackage

// File: rtl/dff_bank_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate req by ptr, priority encode, un-rotate.
module dff_bank_rr_arbiter_rr_pick
  import dff_bank_rr_arbiter_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] w
);

  // Doubled vector so a plain part-select performs the rotation.
  logic [2*N-2:0] dbl;
  logic [N-1:0]   rot;
  int             pos;
  int             sum;

  assign dbl = {req[N-2:0], req};
  assign rot = dbl[ptr +: N];

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    found = 1'b0;
    pos   = 0;
    sum   = 0;
    w     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        pos   = i;
      end
    end
    sum = pos + int'(ptr);
    if (sum >= N) sum = sum - N;
    w = IW'(sum);
  end

endmodule

// File: rtl/dff_bank_rr_arbiter.sv
// Round-robin arbiter with ownership lock loading one shared WIDTH-bit register.
module dff_bank_rr_arbiter
  import dff_bank_rr_arbiter_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic [N-1:0]            req,
  input  logic [N-1:0]            lock,
  input  logic [N*WIDTH-1:0]      d,
  output logic [N-1:0]            gnt,
  output logic [WIDTH-1:0]        q,
  output logic                    q_valid,
  output logic [idx_width(N)-1:0] owner
);

  localparam int IW = idx_width(N);

  state_e           state;
  state_e           state_next;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    ptr_next;
  logic [IW-1:0]    w;
  logic [IW-1:0]    sel;
  logic             found;
  logic             hold;
  logic             win;
  logic [N-1:0]     onehot;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] d_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign d_arr[i] = d[i*WIDTH +: WIDTH];
  end

  dff_bank_rr_arbiter_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .w     (w)
  );

  // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= ARB;
    else        state <= state_next;
  end

  always_comb begin
    hold       = (state == LOCKED) && req[owner] && lock[owner];
    win        = !hold && found;
    state_next = ARB;
    if (hold)                state_next = LOCKED;
    else if (win && lock[w]) state_next = LOCKED;
  end

  always_comb begin
    sel         = hold ? owner : w;
    sel_data    = d_arr[sel];
    onehot      = '0;
    onehot[w]   = 1'b1;
    ptr_next    = (w == IW'(N - 1)) ? '0 : w + 1'b1;
  end

  // NOTE: the data register is reset too, because q must read zero during reset.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      gnt     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      owner   <= '0;
      ptr     <= '0;
    end else if (hold) begin
      q       <= sel_data;
      q_valid <= 1'b1;
    end else if (win) begin
      gnt     <= onehot;
      q       <= sel_data;
      q_valid <= 1'b1;
      owner   <= w;
      ptr     <= ptr_next;
    end else begin
      gnt     <= '0;
      q_valid <= 1'b0;
    end
  end

endmodule
